// File: rtl/keypad_pkg.sv
// Keypad scanner shared helpers: width formulas, key index, level mapping.
// Imported by keypad_scan_fifo for port widths and decode.
package keypad_pkg;

  function automatic int kw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w_f(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int key_idx(input int row, input int col,
                                 input int ncols);
    return row * ncols + col;
  endfunction

  // Maps logical "active" to the pad level (and back).
  function automatic logic lvl(input logic b, input logic al);
    return b ^ al;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word fall-through FIFO, head valid whenever !empty_o.
// Ports: push_i/data_i write, pop_i read, full_o/empty_o status, head_o.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column drive, row sync, per-key debounce, make-event FIFO.
// Ports: row_in/col_out pads, key_code/key_valid/key_ready queue, key_held, overflow.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_ROWS-1:0]                    row_in,
  output logic [N_COLS-1:0]                    col_out,
  output logic [kw_f(N_ROWS*N_COLS)-1:0]       key_code,
  output logic                                 key_valid,
  input  logic                                 key_ready,
  output logic [N_ROWS*N_COLS-1:0]             key_held,
  output logic                                 overflow,
  input  logic                                 clear_overflow
);

  localparam int   NK    = N_ROWS * N_COLS;
  localparam int   KW    = kw_f(NK);
  localparam int   CNT_W = cnt_w_f(DEBOUNCE_SCANS);
  localparam int   SW    = $clog2(SCAN_DIV);
  localparam int   CW    = $clog2(N_COLS);
  localparam int   RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic AL    = (ACTIVE_LOW != 0);

  logic [SW-1:0]     slot_q, slot_d;
  logic [CW-1:0]     col_q, col_d;
  logic [N_COLS-1:0] col_out_q, col_out_d;
  logic [N_ROWS-1:0] s1_q, s2_q;
  logic [NK-1:0]     held_q, held_d;
  logic [CNT_W-1:0]  cnt_q [NK];
  logic [CNT_W-1:0]  cnt_d [NK];
  logic [N_ROWS-1:0] pend_q, pend_d;
  logic [CW-1:0]     pcol_q, pcol_d;
  logic              ovf_q, ovf_d;

  logic              last_slot;
  logic [N_ROWS-1:0] makes;
  logic [N_ROWS-1:0] eff;
  logic [CW-1:0]     ecol;
  logic [RW-1:0]     sel;
  logic [KW-1:0]     k;
  logic              p;
  logic              push;
  logic [KW-1:0]     push_code;
  logic              drop;
  logic              full;
  logic              empty;

  always_comb begin
    last_slot = (slot_q == SW'(SCAN_DIV - 1));
    slot_d    = last_slot ? '0 : slot_q + 1'b1;
    col_d     = col_q;
    if (last_slot)
      col_d = (col_q == CW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
    for (int c = 0; c < N_COLS; c++)
      col_out_d[c] = lvl(col_q == CW'(c), AL);

    held_d = held_q;
    cnt_d  = cnt_q;
    makes  = '0;
    k      = '0;
    p      = 1'b0;
    if (last_slot) begin
      for (int r = 0; r < N_ROWS; r++) begin
        k = KW'(key_idx(r, int'(col_q), N_COLS));
        p = lvl(s2_q[r], AL);
        if (p == held_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
          held_d[k] = p;
          cnt_d[k]  = '0;
          makes[r]  = p;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end

    // Makes of the sampled column join the pending mask; lowest row
    // is pushed now, the rest drain one per cycle.
    eff  = pend_q | makes;
    ecol = last_slot ? col_q : pcol_q;
    sel  = '0;
    for (int r = N_ROWS - 1; r >= 0; r--)
      if (eff[r]) sel = RW'(r);
    push   = |eff;
    pend_d = eff;
    if (push) pend_d[sel] = 1'b0;
    pcol_d    = ecol;
    push_code = KW'(key_idx(int'(sel), int'(ecol), N_COLS));

    drop  = push & full & ~key_ready;
    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clear_overflow)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      col_q  <= '0;
      for (int c = 0; c < N_COLS; c++)
        col_out_q[c] <= lvl(c == 0, AL);
      s1_q   <= '0;
      s2_q   <= '0;
      held_q <= '0;
      cnt_q  <= '{default: '0};
      pend_q <= '0;
      pcol_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
      s1_q      <= row_in;
      s2_q      <= s1_q;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pcol_q    <= pcol_d;
      ovf_q     <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_code),
    .pop_i   (key_ready),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (key_code)
  );

  assign col_out   = col_out_q;
  assign key_valid = ~empty;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo, 4x4, SCAN_DIV=4, DEBOUNCE_SCANS=2.
// An ideal key matrix model drives row_in from col_out.
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key_held;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] keys;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .N_ROWS         (4),
    .N_COLS         (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .row_in         (row_in),
    .col_out        (col_out),
    .key_code       (key_code),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .key_held       (key_held),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic hb(input int k);
    return key_held[k[3:0]];
  endfunction

  task automatic press(input int k, input logic v);
    keys[k[3:0]] = v;
  endtask

  task automatic pop1();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  task automatic wait_held(input int k, input int budget);
    int n;
    n = 0;
    while (!hb(k) && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("held[%0d] set", k), 32'(hb(k)), 32'd1);
  endtask

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    logic [3:0] prev;
    int         n;
    bit         hit;
    tgt = 4'hF;
    tgt[c[1:0]] = 1'b0;
    prev = col_out;
    hit  = 1'b0;
    n    = 0;
    while (!hit && n < 40) begin
      tick();
      n++;
      if (col_out == tgt && prev != tgt) hit = 1'b1;
      prev = col_out;
    end
    chk("col sync", 32'(hit), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " col_out"},   32'(col_out),   32'hE);
    chk({tag, " key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, " key_code"},  32'(key_code),  32'd0);
    chk({tag, " key_held"},  32'(key_held),  32'd0);
    chk({tag, " overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin
    logic [3:0] exp_col;
    int         q5 [4];
    int         q6 [4];
    q5 = '{0, 1, 3, 4};
    q6 = '{11, 12, 13, 15};

    rst            = 1'b1;
    key_ready      = 1'b0;
    clear_overflow = 1'b0;
    keys           = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // 1: idle scan, column k driven during cycles 4k+1..4k+4
    for (int n = 1; n <= 64; n++) begin
      tick();
      exp_col = 4'hF;
      exp_col[2'(((n - 1) / 4) % 4)] = 1'b0;
      chk($sformatf("scan c%0d", n), 32'(col_out), 32'(exp_col));
    end
    chk("idle valid", 32'(key_valid), 32'd0);

    // 2: key 9 press, hold, pop, release
    press(9, 1'b1);
    wait_held(9, 80);
    chk("k9 valid", 32'(key_valid), 32'd1);
    chk("k9 code",  32'(key_code),  32'd9);
    repeat (32) tick();
    chk("k9 still head", 32'(key_code), 32'd9);
    pop1();
    chk("k9 single event", 32'(key_valid), 32'd0);
    press(9, 1'b0);
    repeat (48) tick();
    chk("k9 released", 32'(hb(9)), 32'd0);
    chk("k9 no break ev", 32'(key_valid), 32'd0);

    // 3: key 5 bounces once per scan, then held
    wait_col(3);
    for (int i = 0; i < 4; i++) begin
      press(5, (i % 2) == 0);
      repeat (16) tick();
    end
    chk("k5 bounce held", 32'(hb(5)), 32'd0);
    chk("k5 bounce valid", 32'(key_valid), 32'd0);
    press(5, 1'b1);
    wait_held(5, 80);
    chk("k5 code", 32'(key_code), 32'd5);
    pop1();
    repeat (40) tick();
    chk("k5 one event", 32'(key_valid), 32'd0);
    press(5, 1'b0);
    repeat (48) tick();

    // 4: keys 2 and 14 together, lowest row first
    press(2, 1'b1);
    press(14, 1'b1);
    wait_held(2, 80);
    chk("k14 same flip", 32'(hb(14)), 32'd1);
    chk("pair first", 32'(key_code), 32'd2);
    pop1();
    chk("pair second v", 32'(key_valid), 32'd1);
    chk("pair second", 32'(key_code), 32'd14);
    pop1();
    chk("pair empty", 32'(key_valid), 32'd0);
    press(2, 1'b0);
    press(14, 1'b0);
    repeat (64) tick();

    // 5: six makes with no consumer
    press(0, 1'b1); wait_held(0, 80);
    press(1, 1'b1); wait_held(1, 80);
    press(3, 1'b1); wait_held(3, 80);
    press(4, 1'b1); wait_held(4, 80);
    chk("full no ovf", 32'(overflow), 32'd0);
    press(7, 1'b1); wait_held(7, 80);
    chk("ovf set", 32'(overflow), 32'd1);
    press(8, 1'b1); wait_held(8, 80);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain5 v%0d", i), 32'(key_valid), 32'd1);
      chk($sformatf("drain5 c%0d", i), 32'(key_code), 32'(q5[i]));
      pop1();
    end
    chk("drain5 empty", 32'(key_valid), 32'd0);
    chk("ovf sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf cleared", 32'(overflow), 32'd0);
    keys = '0;
    repeat (64) tick();

    // 6: full FIFO, pop in the make cycle of key 15
    press(10, 1'b1); wait_held(10, 80);
    press(11, 1'b1); wait_held(11, 80);
    press(12, 1'b1); wait_held(12, 80);
    press(13, 1'b1); wait_held(13, 80);
    wait_col(0);
    press(15, 1'b1);
    repeat (30) tick();
    chk("k15 not yet", 32'(hb(15)), 32'd0);
    pop1();
    chk("k15 made", 32'(hb(15)), 32'd1);
    chk("pop+push ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain6 v%0d", i), 32'(key_valid), 32'd1);
      chk($sformatf("drain6 c%0d", i), 32'(key_code), 32'(q6[i]));
      pop1();
    end
    chk("drain6 empty", 32'(key_valid), 32'd0);
    keys = '0;
    repeat (64) tick();

    // reset mid-debounce with queued events
    press(0, 1'b1); wait_held(0, 80);
    press(1, 1'b1); wait_held(1, 80);
    chk("pre-rst valid", 32'(key_valid), 32'd1);
    wait_col(1);
    press(4, 1'b1);
    repeat (20) tick();
    chk("k4 mid debounce", 32'(hb(4)), 32'd0);
    rst = 1'b1;
    tick();
    chk_reset("mid rst");
    rst  = 1'b0;
    keys = '0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
